// File: rtl/alu_pkg.sv
// Shared opcode definitions for the n-bit ALU: class select and per-class operation codes.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam logic ARITH = 1'b0;
  localparam logic LOGIC = 1'b1;

  // Arithmetic class
  localparam op_t OP_ADD   = 3'b000;
  localparam op_t OP_SUB   = 3'b001;
  localparam op_t OP_INC   = 3'b010;
  localparam op_t OP_DEC   = 3'b011;
  localparam op_t OP_NEG   = 3'b100;
  localparam op_t OP_SHL   = 3'b101;
  localparam op_t OP_SHR   = 3'b110;
  localparam op_t OP_PASSA = 3'b111;

  // Logic class
  localparam op_t OP_AND   = 3'b000;
  localparam op_t OP_OR    = 3'b001;
  localparam op_t OP_XOR   = 3'b010;
  localparam op_t OP_NAND  = 3'b011;
  localparam op_t OP_NOR   = 3'b100;
  localparam op_t OP_XNOR  = 3'b101;
  localparam op_t OP_NOTA  = 3'b110;
  localparam op_t OP_PASSB = 3'b111;

endpackage

// File: rtl/alu_nbit_if.sv
// Operand/result bundle for alu_nbit; the master drives operands, the slave returns registered results.
interface alu_nbit_if #(parameter int n = 8);
  import alu_pkg::*;

  logic [n-1:0] a;
  logic [n-1:0] b;
  op_t          sel;
  logic         control;
  logic [n-1:0] y;
  logic         cout;

  modport master (output a, b, sel, control, input y, cout);
  modport slave  (input a, b, sel, control, output y, cout);
endinterface

// File: rtl/alu_addsub_n.sv
// n-bit adder with carry-in and optional inversion of the second operand.
module alu_addsub_n #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         invert_b,
  input  logic         cin,
  output logic [n-1:0] sum,
  output logic         carry
);

  logic [n-1:0] b_eff;
  logic [n:0]   total;

  // One extra bit so the carry out falls naturally into bit n.
  always_comb begin
    b_eff = invert_b ? ~b : b;
    total = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, cin};
  end

  assign sum   = total[n-1:0];
  assign carry = total[n];

endmodule

// File: rtl/alu_nbit.sv
// Parameterised n-bit ALU: arithmetic and logic classes, result and carry registered one cycle later.
module alu_nbit
  import alu_pkg::*;
#(
  parameter int n = 8
) (
  input  logic        clk,
  input  logic        rst,
  alu_nbit_if.slave   bus
);

  logic [n-1:0] add_x;
  logic [n-1:0] add_b;
  logic         add_inv;
  logic         add_cin;
  logic [n-1:0] add_sum;
  logic         add_carry;

  logic [n-1:0] next_y;
  logic         next_cout;
  logic [n-1:0] y_q;
  logic         cout_q;

  // ADD/SUB/INC/DEC/NEG share one adder; DEC adds all-ones, NEG computes 0 + ~a + 1.
  always_comb begin
    add_x   = bus.a;
    add_b   = bus.b;
    add_inv = 1'b0;
    add_cin = 1'b0;
    case (bus.sel)
      OP_SUB: begin add_inv = 1'b1; add_cin = 1'b1; end
      OP_INC: begin add_b = '0; add_cin = 1'b1; end
      OP_DEC: begin add_b = '0; add_inv = 1'b1; end
      OP_NEG: begin add_x = '0; add_b = bus.a; add_inv = 1'b1; add_cin = 1'b1; end
      default: ;
    endcase
  end

  alu_addsub_n #(.n(n)) u_addsub (
    .a        (add_x),
    .b        (add_b),
    .invert_b (add_inv),
    .cin      (add_cin),
    .sum      (add_sum),
    .carry    (add_carry)
  );

  always_comb begin
    next_y    = '0;
    next_cout = 1'b0;
    if (bus.control == ARITH) begin
      case (bus.sel)
        OP_SHL:   begin next_y = {bus.a[n-2:0], 1'b0}; next_cout = bus.a[n-1]; end
        OP_SHR:   begin next_y = {1'b0, bus.a[n-1:1]}; next_cout = bus.a[0]; end
        OP_PASSA: next_y = bus.a;
        default:  begin next_y = add_sum; next_cout = add_carry; end
      endcase
    end else begin
      case (bus.sel)
        OP_AND:   next_y = bus.a & bus.b;
        OP_OR:    next_y = bus.a | bus.b;
        OP_XOR:   next_y = bus.a ^ bus.b;
        OP_NAND:  next_y = ~(bus.a & bus.b);
        OP_NOR:   next_y = ~(bus.a | bus.b);
        OP_XNOR:  next_y = ~(bus.a ^ bus.b);
        OP_NOTA:  next_y = ~bus.a;
        default:  next_y = bus.b;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      y_q    <= next_y;
      cout_q <= next_cout;
    end
  end

  assign bus.y    = y_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_alu_nbit.sv
// Scoreboard bench for alu_nbit: expectations queued at drive time, checked one edge later.
module tb_alu_nbit;
  import alu_pkg::*;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_nbit_if #(.n(N)) bus ();

  alu_nbit #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [N:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  vectors     = 0;
  int  miscompares = 0;

  // Independent reference: expected {cout, y} from the operation table.
  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic [2:0] s, input logic c);
    logic [N-1:0] r;
    logic         f;
    r = '0;
    f = 1'b0;
    if (c == ARITH) begin
      case (s)
        OP_ADD:   begin r = a + b; f = ({1'b0, a} + {1'b0, b}) > (N+1)'((1 << N) - 1); end
        OP_SUB:   begin r = a - b; f = (a >= b); end
        OP_INC:   begin r = a + 1'b1; f = (a == {N{1'b1}}); end
        OP_DEC:   begin r = a - 1'b1; f = (a != '0); end
        OP_NEG:   begin r = '0 - a; f = (a == '0); end
        OP_SHL:   begin r = a << 1; f = a[N-1]; end
        OP_SHR:   begin r = a >> 1; f = a[0]; end
        default:  r = a;
      endcase
    end else begin
      case (s)
        OP_AND:   r = a & b;
        OP_OR:    r = a | b;
        OP_XOR:   r = a ^ b;
        OP_NAND:  r = ~(a & b);
        OP_NOR:   r = ~(a | b);
        OP_XNOR:  r = ~(a ^ b);
        OP_NOTA:  r = ~a;
        default:  r = b;
      endcase
    end
    return {f, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [N:0] observed, input logic [N:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got cout=%0b y=%0h, want cout=%0b y=%0h",
               tag, observed[N], observed[N-1:0], expected[N], expected[N-1:0]);
    end
  endtask

  task automatic popAndCheck();
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput(e.tag, {bus.cout, bus.y}, e.exp);
    end
  endtask

  // Check what the previous edge produced, then drive the next operation and queue its expectation.
  task automatic applyStimulus(input string tag, input logic r, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [2:0] s, input logic c,
                               input logic [N:0] exp);
    sb_t e;
    @(negedge clk);
    popAndCheck();
    rst         = r;
    bus.a       = a;
    bus.b       = b;
    bus.sel     = s;
    bus.control = c;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  logic [N-1:0] ra, rb;
  logic [2:0]   rs;
  logic         rc;
  localparam logic [N-1:0] LA = 8'b1100_1010;
  localparam logic [N-1:0] LB = 8'b1010_0110;

  initial begin
    rst         = 1'b1;
    bus.a       = '0;
    bus.b       = '0;
    bus.sel     = OP_ADD;
    bus.control = ARITH;

    applyStimulus("rst0", 1'b1, 8'hFF, 8'hFF, OP_ADD, ARITH, 9'h000);
    applyStimulus("rst1", 1'b1, 8'hFF, 8'hFF, OP_ADD, ARITH, 9'h000);
    applyStimulus("rst_release", 1'b0, 8'hFF, 8'hFF, OP_ADD, ARITH, {1'b1, 8'hFE});

    applyStimulus("add_wrap", 1'b0, 8'd200, 8'd100, OP_ADD, ARITH, {1'b1, 8'd44});
    applyStimulus("sub_borrow", 1'b0, 8'd100, 8'd200, OP_SUB, ARITH, {1'b0, 8'd156});
    applyStimulus("sub_noborrow", 1'b0, 8'd200, 8'd100, OP_SUB, ARITH, {1'b1, 8'd100});

    applyStimulus("inc_ff", 1'b0, 8'd255, 8'd0, OP_INC, ARITH, {1'b1, 8'd0});
    applyStimulus("dec_00", 1'b0, 8'd0, 8'd0, OP_DEC, ARITH, {1'b0, 8'd255});
    applyStimulus("neg_00", 1'b0, 8'd0, 8'd0, OP_NEG, ARITH, {1'b1, 8'd0});
    applyStimulus("neg_01", 1'b0, 8'd1, 8'd0, OP_NEG, ARITH, {1'b0, 8'd255});

    applyStimulus("shl", 1'b0, 8'b1000_0001, 8'd0, OP_SHL, ARITH, {1'b1, 8'b0000_0010});
    applyStimulus("shr", 1'b0, 8'b1000_0001, 8'd0, OP_SHR, ARITH, {1'b1, 8'b0100_0000});
    applyStimulus("passa", 1'b0, 8'h5A, 8'h33, OP_PASSA, ARITH, {1'b0, 8'h5A});

    applyStimulus("and",   1'b0, LA, LB, OP_AND,   LOGIC, {1'b0, 8'b1000_0010});
    applyStimulus("or",    1'b0, LA, LB, OP_OR,    LOGIC, {1'b0, 8'b1110_1110});
    applyStimulus("xor",   1'b0, LA, LB, OP_XOR,   LOGIC, {1'b0, 8'b0110_1100});
    applyStimulus("nand",  1'b0, LA, LB, OP_NAND,  LOGIC, {1'b0, 8'b0111_1101});
    applyStimulus("nor",   1'b0, LA, LB, OP_NOR,   LOGIC, {1'b0, 8'b0001_0001});
    applyStimulus("xnor",  1'b0, LA, LB, OP_XNOR,  LOGIC, {1'b0, 8'b1001_0011});
    applyStimulus("nota",  1'b0, LA, LB, OP_NOTA,  LOGIC, {1'b0, 8'b0011_0101});
    applyStimulus("passb", 1'b0, LA, LB, OP_PASSB, LOGIC, {1'b0, 8'b1010_0110});

    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 3'($urandom_range(0, 7));
      rc = 1'($urandom_range(0, 1));
      applyStimulus("rand", 1'b0, ra, rb, rs, rc, model(ra, rb, rs, rc));
    end

    ra = N'($urandom);
    rb = N'($urandom);
    applyStimulus("mid_rst", 1'b1, ra, rb, OP_ADD, ARITH, 9'h000);

    for (int i = 0; i < 4; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 3'($urandom_range(0, 7));
      rc = 1'($urandom_range(0, 1));
      applyStimulus("resume", 1'b0, ra, rb, rs, rc, model(ra, rb, rs, rc));
    end

    @(negedge clk);
    popAndCheck();
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
